// File: rtl/alu_arbiter_if.sv
// Two-port request/response handshake bundle plus the shared-ALU side-band.
// The slave modport is the arbiter; the master modport is the environment.
interface alu_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req1_a;
    logic [WIDTH-1:0] req0_b, req1_b;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             last_grant;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
               alu_a, alu_b, alu_ctrl, last_grant
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b,
               req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
               alu_a, alu_b, alu_ctrl, last_grant
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, with a
// one-entry registered response buffer per port.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus
);
    logic elig0, elig1;
    logic gnt0, gnt1;

    // A port may issue in the same cycle its buffer is being drained.
    assign elig0 = bus.req0_valid && (!bus.rsp0_valid || bus.rsp0_ready);
    assign elig1 = bus.req1_valid && (!bus.rsp1_valid || bus.rsp1_ready);

    assign gnt0 = !reset && elig0 && (!elig1 || bus.last_grant);
    assign gnt1 = !reset && elig1 && (!elig0 || !bus.last_grant);

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    always_comb begin
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = 4'b0000;
        if (gnt0) begin
            bus.alu_a    = bus.req0_a;
            bus.alu_b    = bus.req0_b;
            bus.alu_ctrl = bus.req0_ctrl;
        end else if (gnt1) begin
            bus.alu_a    = bus.req1_a;
            bus.alu_b    = bus.req1_b;
            bus.alu_ctrl = bus.req1_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp0_valid  <= 1'b0;
            bus.rsp1_valid  <= 1'b0;
            bus.rsp0_result <= '0;
            bus.rsp1_result <= '0;
            bus.rsp0_zero   <= 1'b0;
            bus.rsp1_zero   <= 1'b0;
            bus.last_grant  <= 1'b1;
        end else begin
            // A grant on the same edge as a consume reloads the buffer.
            if (gnt0) begin
                bus.rsp0_result <= bus.alu_result;
                bus.rsp0_zero   <= bus.alu_zero;
                bus.rsp0_valid  <= 1'b1;
            end else if (bus.rsp0_ready) begin
                bus.rsp0_valid  <= 1'b0;
            end
            if (gnt1) begin
                bus.rsp1_result <= bus.alu_result;
                bus.rsp1_zero   <= bus.alu_zero;
                bus.rsp1_valid  <= 1'b1;
            end else if (bus.rsp1_ready) begin
                bus.rsp1_valid  <= 1'b0;
            end
            if (gnt0)      bus.last_grant <= 1'b0;
            else if (gnt1) bus.last_grant <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Shared ALU model: undefined codes give result 0.
    always_comb begin
        case (bus.alu_ctrl)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b0111: bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c;
    endtask

    initial begin
        reset = 1'b1;
        drive0(1'b1, 32'd1, 32'd1, 4'b0010);
        drive1(1'b0, '0, '0, 4'b0000);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        tick();
        tick();
        // Reset state; ready stays low while reset is high even with valid set.
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_alu_ctrl", bus.alu_ctrl, 0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 0);
        chk("rst_rsp1_valid", bus.rsp1_valid, 0);
        chk("rst_rsp0_result", bus.rsp0_result, 0);
        chk("rst_rsp1_zero", bus.rsp1_zero, 0);
        chk("rst_last_grant", bus.last_grant, 1);

        // Single op: ADD 5+7.
        reset = 1'b0;
        drive0(1'b1, 32'd5, 32'd7, 4'b0010);
        #1;
        chk("single_req0_ready", bus.req0_ready, 1);
        chk("single_req1_ready", bus.req1_ready, 0);
        chk("single_alu_a", bus.alu_a, 5);
        chk("single_alu_ctrl", bus.alu_ctrl, 4'b0010);
        tick();
        drive0(1'b0, '0, '0, 4'b0000);
        chk("single_rsp0_valid", bus.rsp0_valid, 1);
        chk("single_rsp0_result", bus.rsp0_result, 12);
        chk("single_rsp0_zero", bus.rsp0_zero, 0);
        chk("single_last_grant", bus.last_grant, 0);
        bus.rsp0_ready = 1'b1;
        tick();
        chk("single_consumed", bus.rsp0_valid, 0);

        // Tie after reset, then sustained alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive0(1'b1, 32'd9, 32'd9, 4'b0110);
        drive1(1'b1, 32'h0F, 32'hF0, 4'b0001);
        #1;
        chk("tie_req0_ready", bus.req0_ready, 1);
        chk("tie_req1_ready", bus.req1_ready, 0);
        tick();
        chk("tie_rsp0_result", bus.rsp0_result, 0);
        chk("tie_rsp0_zero", bus.rsp0_zero, 1);
        chk("tie_lg0", bus.last_grant, 0);
        chk("tie_req1_ready2", bus.req1_ready, 1);
        chk("tie_req0_ready2", bus.req0_ready, 0);
        tick();
        chk("tie_rsp1_result", bus.rsp1_result, 32'hFF);
        chk("tie_lg1", bus.last_grant, 1);
        chk("tie_req0_ready3", bus.req0_ready, 1);
        tick();
        chk("tie_lg2", bus.last_grant, 0);
        drive0(1'b0, '0, '0, 4'b0000);
        drive1(1'b0, '0, '0, 4'b0000);
        tick();
        chk("tie_drained0", bus.rsp0_valid, 0);
        chk("tie_drained1", bus.rsp1_valid, 0);

        // Backpressure on port 1 while port 0 keeps full access.
        bus.rsp1_ready = 1'b0;
        drive1(1'b1, 32'd3, 32'd4, 4'b0111);
        #1;
        chk("bp_req1_first", bus.req1_ready, 1);
        tick();
        drive1(1'b1, 32'd10, 32'd2, 4'b0111);
        drive0(1'b1, 32'd1, 32'd1, 4'b0010);
        #1;
        chk("bp_rsp1_result", bus.rsp1_result, 1);
        chk("bp_req1_blocked", bus.req1_ready, 0);
        chk("bp_req0_go", bus.req0_ready, 1);
        tick();
        chk("bp_rsp0_result", bus.rsp0_result, 2);
        chk("bp_rsp1_held", bus.rsp1_result, 1);
        chk("bp_rsp1_valid", bus.rsp1_valid, 1);
        chk("bp_req1_still_blocked", bus.req1_ready, 0);
        chk("bp_req0_go2", bus.req0_ready, 1);
        tick();
        drive0(1'b0, '0, '0, 4'b0000);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_req1_release", bus.req1_ready, 1);
        tick();
        drive1(1'b0, '0, '0, 4'b0000);
        chk("bp_rsp1_valid2", bus.rsp1_valid, 1);
        chk("bp_rsp1_result2", bus.rsp1_result, 0);
        chk("bp_rsp1_zero2", bus.rsp1_zero, 1);
        tick();
        chk("bp_rsp1_drained", bus.rsp1_valid, 0);

        // Streaming on port 0, one op per cycle.
        for (int i = 1; i <= 8; i++) begin
            drive0(1'b1, i, i, 4'b0010);
            #1;
            chk("stream_ready", bus.req0_ready, 1);
            tick();
            chk("stream_valid", bus.rsp0_valid, 1);
            chk("stream_result", bus.rsp0_result, 2 * i);
        end
        drive0(1'b0, '0, '0, 4'b0000);
        tick();

        // Reset mid-operation: a buffered port-0 response and a port-1 grant are lost.
        bus.rsp0_ready = 1'b0;
        drive0(1'b1, 32'd2, 32'd3, 4'b0010);
        tick();
        drive0(1'b0, '0, '0, 4'b0000);
        chk("mid_rsp0_pending", bus.rsp0_valid, 1);
        drive1(1'b1, 32'hF0F0, 32'hFFFF, 4'b0000);
        #1;
        chk("mid_req1_ready", bus.req1_ready, 1);
        reset = 1'b1;
        #1;
        chk("mid_req1_ready_rst", bus.req1_ready, 0);
        tick();
        drive1(1'b0, '0, '0, 4'b0000);
        reset = 1'b0;
        chk("mid_rsp1_valid", bus.rsp1_valid, 0);
        chk("mid_rsp1_result", bus.rsp1_result, 0);
        chk("mid_rsp0_valid", bus.rsp0_valid, 0);
        chk("mid_last_grant", bus.last_grant, 1);
        tick();
        chk("mid_no_late_rsp1", bus.rsp1_valid, 0);

        // Idle bus, then an undefined ctrl code.
        chk("idle_alu_a", bus.alu_a, 0);
        chk("idle_alu_b", bus.alu_b, 0);
        chk("idle_alu_ctrl", bus.alu_ctrl, 0);
        drive0(1'b1, 32'd5, 32'd3, 4'b1111);
        #1;
        chk("undef_alu_ctrl", bus.alu_ctrl, 4'b1111);
        tick();
        drive0(1'b0, '0, '0, 4'b0000);
        chk("undef_rsp0_result", bus.rsp0_result, 0);
        chk("undef_rsp0_zero", bus.rsp0_zero, 1);
        chk("undef_rsp0_valid", bus.rsp0_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter that shares the single 32-bit ALU between two requesters, for example the EX stage and an address/branch-compare unit. Each requester issues operations over a valid/ready handshake. The arbiter drives the shared ALU for the winning requester and registers the ALU result and zero flag. It holds that result in a one-entry response buffer per port until the owner accepts it. Total throughput is one ALU operation per cycle; latency from accepted request to response is one cycle.

## Interface
- WIDTH, 32, operand/result width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle (grant)
- req0_a / req1_a  in  WIDTH  operand A
- req0_b / req1_b  in  WIDTH  operand B
- req0_ctrl / req1_ctrl  in  4  ALU control code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT)
- rsp0_valid / rsp1_valid  out  1  response buffer full
- rsp0_ready / rsp1_ready  in  1  requester consumes response
- rsp0_result / rsp1_result  out  WIDTH  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered zero flag
- alu_a, alu_b  out  WIDTH  operands to shared ALU
- alu_ctrl  out  4  control to shared ALU
- alu_result  in  WIDTH  combinational ALU result
- alu_zero  in  1  combinational ALU zero flag
- last_grant  out  1  port index of most recent grant

## Operation
- The clock is clk. Reset is reset: synchronous and active-high.
- A transfer occurs when reqN_valid && reqN_ready at a rising edge. A response is consumed when rspN_valid && rspN_ready.
- Port N is eligible when reqN_valid && (!rspN_valid || rspN_ready). An eligible port may issue in the same cycle its buffer drains.
- Grant rules:
  - Only one port eligible: that port wins.
  - Both ports eligible: the port != last_grant wins.
  - No port eligible: no grant.
- reqN_ready = 1 only for the granted port. It is combinational from the valid, rsp_valid/rsp_ready and last_grant signals.
- Requesters must not derive valid from ready. Operands and ctrl must stay stable while valid && !ready.
- With a grant, alu_a/alu_b/alu_ctrl carry the granted port's fields. Without a grant they are 0/0/0000.
- On the grant edge, rspN_result <= alu_result, rspN_zero <= alu_zero, rspN_valid <= 1, and last_grant <= N.
- rspN_valid clears on consume unless a new grant to N occurs on the same edge. In that case the buffer reloads and valid stays 1.
- An unconsumed response blocks its own port only. The other port keeps full access.
- ctrl codes are passed through unchanged. Undefined codes yield whatever the ALU returns (result 0, zero 1).
- Arithmetic is performed entirely by the ALU. The arbiter does no width changes.

## Timing
- Reset values:
  - req0/1_ready = 0
  - rsp0/1_valid = 0
  - rsp0/1_result = 0
  - rsp0/1_zero = 0
  - alu_a = alu_b = 0, alu_ctrl = 0000
  - last_grant = 1, so port 0 wins the first tie
- Reset asserted mid-operation discards both buffered responses and any same-cycle grant. No response for that grant is ever produced.
- While reset is high, req*_ready = 0.
- Latency: request accepted at edge k gives rspN_valid = 1 after edge k, visible in cycle k+1.
- Back-to-back requests from one port with rsp_ready held high achieve one op per cycle when the other port is idle.
- Under constant contention, grants alternate 0,1,0,1… Neither port waits more than one cycle for a grant once its buffer is free.
- Simultaneous events:
  - Consume and new grant on the same port and edge: new data is loaded and valid stays 1.
  - Consume on one port with a grant to the other: independent.

## Test plan
- Single op: reset, then port 0 ADD a=5 b=7. Expect req0_ready=1 same cycle; rsp0_valid=1, rsp0_result=12, rsp0_zero=0 next cycle; last_grant=0.
- Tie after reset: both ports valid (port0 SUB 9−9, port1 OR 0x0F|0xF0). Expect port 0 first (result 0, zero=1), port 1 next cycle (result 0xFF). Grants then alternate under sustained contention.
- Backpressure: port 1 SLT 3<4 with rsp1_ready=0, then a second port-1 request.
  - Expect rsp1_result=1 held and req1_ready=0 while blocked.
  - Meanwhile port-0 requests are granted every cycle.
  - Asserting rsp1_ready grants the second request the same cycle.
- Streaming: port 0 issues ADD i+i for i=1..8 with rsp0_ready=1 and port 1 idle. Expect 8 responses on 8 consecutive cycles: 2,4,…,16.
- Reset mid-operation: grant port 1 AND 0xF0F0&0xFFFF and assert reset on that edge. Expect rsp1_valid=0, rsp1_result=0, last_grant=1 after reset.
- Idle/undefined: no valid requests, so expect alu_a=alu_b=0 and alu_ctrl=0000. Port 0 ctrl=1111 returns result 0, zero=1.
